amber128_slot_sequencer: RTL and testbench
==========================================

// Module: amber128_slot_sequencer
// PURPOSE
//  Steps the amber128_decoder through one 128-bit bundle, one issue item at a time.
//  A bundle holds 5 slots (S0..S4). A slot is either one 24-bit op or two 12-bit ops.
//  Sits between fetch and decode/issue: latches a bundle, drives slot_idx/sub12 plus the held
//  bundle to the decoder, and accepts the next bundle with zero bubbles.
//  Redirect/flush drops the held bundle at once.
// PARAMETERS
//  WORD_ADDR_W  28  width of the bundle word address (16-byte units)
//  STALL_CNT_W  16  width of the saturating issue-stall counter
// PORTS
//  clk_i            in   1            clock; all state updates on rising edge
//  rst_i            in   1            synchronous reset, active-high
//  bundle_valid_i   in   1            fetch offers a bundle
//  bundle_i         in   128          bundle; flags [127:123], S0 [119:96] ... S4 [23:0]
//  bundle_addr_i    in   WORD_ADDR_W  word address of bundle_i
//  bundle_ready_o   out  1            sequencer accepts bundle_i this cycle
//  slot_valid_o     out  1            issue item presented to decoder/issue
//  slot_ready_i     in   1            downstream takes the item this cycle
//  bundle_o         out  128          held bundle (decoder fetch_i.bundle)
//  word_addr_o      out  WORD_ADDR_W  held address (decoder fetch_i.word_addr)
//  slot_idx_o       out  3            current slot 0..4 (decoder slot_idx_i)
//  sub12_o          out  1            0 = first/only op, 1 = second 12-bit op (decoder sub12_i)
//  last_o           out  1            current item is the final item of the bundle
//  flush_i          in   1            redirect: drop held bundle, ignore bundle_i this cycle
//  stall_cnt_o      out  STALL_CNT_W  cycles with slot_valid_o & !slot_ready_i, saturating
// BEHAVIOUR
//  - Reset: state IDLE; slot_valid_o=0, slot_idx_o=0, sub12_o=0, last_o=0, bundle_o=0,
//    word_addr_o=0, stall_cnt_o=0. bundle_ready_o=0 during the reset cycle.
//  - States: IDLE (nothing held), ISSUE (bundle held, item presented).
//  - two12(s) = held_flags[4-s]. last_o = (idx==4) & (!two12(4) | sub12).
//  - bundle_ready_o = !flush_i & (IDLE | (slot_valid_o & slot_ready_i & last_o)). Combinational.
//  - Accept (bundle_valid_i & bundle_ready_o): latch bundle/addr, idx=0, sub12=0, go to ISSUE.
//    slot_valid_o=1 on the next cycle. Fetch-to-issue latency is 1 cycle.
//  - Advance on slot_valid_o & slot_ready_i:
//    - two12(idx) & !sub12: sub12 becomes 1, idx unchanged.
//    - Otherwise, if !last_o: idx+1, sub12 becomes 0.
//    - If last_o: reload if a bundle is accepted the same cycle, else go to IDLE.
//  - Items per bundle = 5 + popcount(flags), range 5..10. Back-to-back bundles have no gap.
//  - No advance while slot_valid_o & !slot_ready_i. All outputs hold stable (valid/ready rule).
//  - flush_i has priority over everything:
//    - Next state IDLE, slot_valid_o=0; any item offered in that cycle is discarded.
//    - bundle_ready_o=0 in that cycle; stall_cnt_o holds.
//  - Held bundle_o and word_addr_o are not cleared on flush or on going IDLE; only valid drops.
//  - stall_cnt_o increments by 1 per stall cycle and saturates at all-ones.
//    It clears only on rst_i.
// CONFIGURATION
//  AMBER128_SKIP_NOP_EN defined:
//  - A 12-bit item whose opcode bits [11:8]==4'h0 (nop) is skipped.
//  - The skip takes one cycle with slot_valid_o=0. idx/sub12 advance as if the item were accepted.
//  - A skipped last item completes the bundle: bundle_ready_o=1 that cycle (unless flush_i).
//  - Skip cycles do not count as stalls.
//  Undefined: every item is presented, nops included. No skip logic is built.
// TESTING
//  1. flags=5'b00000, slot_ready_i=1 -> 5 items, (idx,sub)=(0,0)..(4,0).
//     last_o only on idx 4; bundle_ready_o=1 in that cycle.
//  2. flags=5'b10001 -> 7 items: (0,0)(0,1)(1,0)(2,0)(3,0)(4,0)(4,1); last_o on (4,1).
//  3. Two bundles back-to-back, bundle_valid_i held high, flags=0 -> 10 consecutive valid
//     cycles, no bubble; word_addr_o changes on item 6.
//  4. slot_ready_i=0 for 3 cycles at (2,0) -> outputs stable, stall_cnt_o +3,
//     then resumes at (3,0).
//  5. flush_i at (1,0) with bundle_valid_i=1 -> bundle not accepted, slot_valid_o=0 next cycle;
//     next bundle accepted starts at (0,0).
//  6. AMBER128_SKIP_NOP_EN, flags=5'b00001, S4=24'h000_123 -> (4,0) skipped; (4,1) issued as last.
//     Undefined macro -> (4,0) issued.

Source files
------------

// File: rtl/amber128_slot_sequencer.sv
// Issue sequencer for 128-bit amber128 bundles: holds one bundle and walks its 5..10 items.
// Optional build macro AMBER128_SKIP_NOP_EN drops 12-bit nop items in a single invisible cycle.
module amber128_slot_sequencer #(
  parameter int WORD_ADDR_W = 28,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bundle_valid_i,
  input  logic [127:0]           bundle_i,
  input  logic [WORD_ADDR_W-1:0] bundle_addr_i,
  output logic                   bundle_ready_o,
  output logic                   slot_valid_o,
  input  logic                   slot_ready_i,
  output logic [127:0]           bundle_o,
  output logic [WORD_ADDR_W-1:0] word_addr_o,
  output logic [2:0]             slot_idx_o,
  output logic                   sub12_o,
  output logic                   last_o,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // while valid is high and ready is low the offering side holds all of its outputs stable.

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [127:0]           bundle_q;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [2:0]             idx_q, idx_d;
  logic                   sub12_q, sub12_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic [4:0] flags;
  logic       two12_cur;
  logic       skip;
  logic       advance;
  logic       accept;
  logic       stall;

  assign flags = bundle_q[127:123];

  // flags[4] describes S0, flags[0] describes S4.
  always_comb begin
    two12_cur = 1'b0;
    case (idx_q)
      3'd0:    two12_cur = flags[4];
      3'd1:    two12_cur = flags[3];
      3'd2:    two12_cur = flags[2];
      3'd3:    two12_cur = flags[1];
      3'd4:    two12_cur = flags[0];
      default: two12_cur = 1'b0;
    endcase
  end

`ifdef AMBER128_SKIP_NOP_EN
  logic [3:0] op_hi;
  logic [3:0] op_lo;
  logic [3:0] op_cur;

  // Opcode nibble of each 12-bit half: the upper half is the first op of the slot.
  always_comb begin
    op_hi = 4'hf;
    op_lo = 4'hf;
    case (idx_q)
      3'd0: begin op_hi = bundle_q[119:116]; op_lo = bundle_q[107:104]; end
      3'd1: begin op_hi = bundle_q[95:92];   op_lo = bundle_q[83:80];   end
      3'd2: begin op_hi = bundle_q[71:68];   op_lo = bundle_q[59:56];   end
      3'd3: begin op_hi = bundle_q[47:44];   op_lo = bundle_q[35:32];   end
      3'd4: begin op_hi = bundle_q[23:20];   op_lo = bundle_q[11:8];    end
      default: begin op_hi = 4'hf; op_lo = 4'hf; end
    endcase
  end

  assign op_cur = sub12_q ? op_lo : op_hi;
  assign skip   = (state_q == ISSUE) && two12_cur && (op_cur == 4'h0);
`else
  assign skip = 1'b0;
`endif

  assign slot_valid_o   = (state_q == ISSUE) && !skip;
  assign last_o         = (state_q == ISSUE) && (idx_q == 3'd4) && (!flags[0] || sub12_q);
  assign advance        = (slot_valid_o && slot_ready_i) || skip;
  assign bundle_ready_o = !rst_i && !flush_i && ((state_q == IDLE) || (advance && last_o));
  assign accept         = bundle_valid_i && bundle_ready_o;
  assign stall          = slot_valid_o && !slot_ready_i && !flush_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sub12_d = sub12_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      if (advance) begin
        if (two12_cur && !sub12_q) begin
          sub12_d = 1'b1;
        end else if (!last_o) begin
          idx_d   = idx_q + 3'd1;
          sub12_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      // A new bundle overrides the drain-to-idle of the finishing one.
      if (accept) begin
        state_d = ISSUE;
        idx_d   = 3'd0;
        sub12_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bundle_q <= '0;
      addr_q   <= '0;
      idx_q    <= 3'd0;
      sub12_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sub12_q <= sub12_d;
      if (accept) begin
        bundle_q <= bundle_i;
        addr_q   <= bundle_addr_i;
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bundle_o    = bundle_q;
  assign word_addr_o = addr_q;
  assign slot_idx_o  = idx_q;
  assign sub12_o     = sub12_q;
  assign stall_cnt_o = stall_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_amber128_slot_sequencer.sv
// Directed bench for amber128_slot_sequencer; expectations follow AMBER128_SKIP_NOP_EN when defined.
module tb_amber128_slot_sequencer;

  localparam int WORD_ADDR_W = 28;
  localparam int STALL_CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   bundle_valid = 1'b0;
  logic [127:0]           bundle = '0;
  logic [WORD_ADDR_W-1:0] bundle_addr = '0;
  logic                   bundle_ready;
  logic                   slot_valid;
  logic                   slot_ready = 1'b0;
  logic [127:0]           bundle_out;
  logic [WORD_ADDR_W-1:0] word_addr;
  logic [2:0]             slot_idx;
  logic                   sub12;
  logic                   last;
  logic                   flush = 1'b0;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  amber128_slot_sequencer #(
    .WORD_ADDR_W(WORD_ADDR_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bundle_valid_i(bundle_valid),
    .bundle_i(bundle),
    .bundle_addr_i(bundle_addr),
    .bundle_ready_o(bundle_ready),
    .slot_valid_o(slot_valid),
    .slot_ready_i(slot_ready),
    .bundle_o(bundle_out),
    .word_addr_o(word_addr),
    .slot_idx_o(slot_idx),
    .sub12_o(sub12),
    .last_o(last),
    .flush_i(flush),
    .stall_cnt_o(stall_cnt),
    .dbg_state_o(dbg_state)
  );

`ifdef AMBER128_SKIP_NOP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  function automatic logic [127:0] make_bundle(input logic [4:0] flags, input logic [23:0] fill);
    return {flags, 3'b000, fill, fill, fill, fill, fill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [127:0] b, input logic [WORD_ADDR_W-1:0] a);
    bundle       = b;
    bundle_addr  = a;
    bundle_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bundle_valid = 1'b1;
    bundle       = make_bundle(5'b11111, 24'ha5a5a5);
    slot_ready   = 1'b1;
    step();
    step();
    vectors++;
    if (bundle_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 0", bundle_ready);
    end
    rst          = 1'b0;
    bundle_valid = 1'b0;
    #1;
    vectors++;
    if ({slot_valid, slot_idx, sub12, last, dbg_state} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0", {slot_valid, slot_idx, sub12, last, dbg_state});
    end
    vectors++;
    if ({bundle_out, word_addr, stall_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h/%h/%h exp 0", bundle_out, word_addr, stall_cnt);
    end
  endtask

  task automatic test_plain();
    logic [127:0] b;
    b = make_bundle(5'b00000, 24'h3c3c3c);
    offer(b, 28'h0000100);
    slot_ready = 1'b1;
    #1;
    vectors++;
    if (bundle_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL plain_accept got %b exp 1", bundle_ready);
    end
    step();
    bundle_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, last, bundle_ready} !== {1'b1, 3'(k), 1'b0, k == 4, k == 4}) begin
        miscompares++;
        $display("FAIL plain_item k=%0d got %b exp %b", k, {slot_valid, slot_idx, sub12, last, bundle_ready},
                 {1'b1, 3'(k), 1'b0, k == 4, k == 4});
      end
      vectors++;
      if ({bundle_out, word_addr} !== {b, 28'h0000100}) begin
        miscompares++;
        $display("FAIL plain_data k=%0d got %h/%h", k, bundle_out, word_addr);
      end
      step();
    end
    vectors++;
    if (slot_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL plain_idle got %b exp 0", slot_valid);
    end
  endtask

  task automatic test_two12();
    logic [2:0] exp_idx [7];
    logic       exp_sub [7];
    exp_idx = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_sub = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    offer(make_bundle(5'b10001, 24'ha5a5a5), 28'h0000200);
    step();
    bundle_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, last} !== {1'b1, exp_idx[k], exp_sub[k], k == 6}) begin
        miscompares++;
        $display("FAIL two12_item k=%0d got %b exp %b", k, {slot_valid, slot_idx, sub12, last},
                 {1'b1, exp_idx[k], exp_sub[k], k == 6});
      end
      step();
    end
    vectors++;
    if (slot_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL two12_idle got %b exp 0", slot_valid);
    end
  endtask

  task automatic test_all_two12();
    offer(make_bundle(5'b11111, 24'h5a5a5a), 28'h0000300);
    step();
    bundle_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, last} !== {1'b1, 3'(k / 2), k % 2 == 1, k == 9}) begin
        miscompares++;
        $display("FAIL all12_item k=%0d got %b exp %b", k, {slot_valid, slot_idx, sub12, last},
                 {1'b1, 3'(k / 2), k % 2 == 1, k == 9});
      end
      step();
    end
    vectors++;
    if (slot_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL all12_idle got %b exp 0", slot_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [WORD_ADDR_W-1:0] exp_addr;
    offer(make_bundle(5'b00000, 24'h111111), 28'h0000400);
    step();
    offer(make_bundle(5'b00000, 24'h222222), 28'h0000401);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) bundle_valid = 1'b0;
      exp_addr = (k < 5) ? 28'h0000400 : 28'h0000401;
      #1;
      vectors++;
      if ({slot_valid, slot_idx, bundle_ready, word_addr} !== {1'b1, 3'(k % 5), k % 5 == 4, exp_addr}) begin
        miscompares++;
        $display("FAIL b2b_item k=%0d got v=%b i=%0d r=%b a=%h exp i=%0d a=%h", k, slot_valid, slot_idx,
                 bundle_ready, word_addr, k % 5, exp_addr);
      end
      step();
    end
    vectors++;
    if (slot_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle got %b exp 0", slot_valid);
    end
  endtask

  task automatic test_stall();
    offer(make_bundle(5'b00000, 24'h777777), 28'h0000500);
    slot_ready = 1'b1;
    step();
    bundle_valid = 1'b0;
    step();
    step();
    slot_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, last, stall_cnt} !== {1'b1, 3'd2, 1'b0, 1'b0, 16'(j)}) begin
        miscompares++;
        $display("FAIL stall_hold j=%0d got v=%b i=%0d cnt=%0d exp i=2 cnt=%0d", j, slot_valid, slot_idx,
                 stall_cnt, j);
      end
      step();
    end
    slot_ready = 1'b1;
    #1;
    vectors++;
    if ({slot_valid, slot_idx, stall_cnt} !== {1'b1, 3'd2, 16'd3}) begin
      miscompares++;
      $display("FAIL stall_count got i=%0d cnt=%0d exp i=2 cnt=3", slot_idx, stall_cnt);
    end
    step();
    #1;
    vectors++;
    if ({slot_valid, slot_idx, sub12} !== {1'b1, 3'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_resume got v=%b i=%0d s=%b exp 1/3/0", slot_valid, slot_idx, sub12);
    end
    step();
    step();
  endtask

  task automatic test_flush();
    logic [127:0] b5;
    logic [127:0] b6;
    b5 = make_bundle(5'b00000, 24'h555555);
    b6 = make_bundle(5'b00000, 24'h666666);
    offer(b5, 28'h0000600);
    slot_ready = 1'b1;
    step();
    bundle_valid = 1'b0;
    step();
    offer(b6, 28'h0000601);
    flush      = 1'b1;
    slot_ready = 1'b0;
    #1;
    vectors++;
    if ({bundle_ready, slot_valid, slot_idx} !== {1'b0, 1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL flush_cycle got r=%b v=%b i=%0d exp 0/1/1", bundle_ready, slot_valid, slot_idx);
    end
    step();
    flush        = 1'b0;
    bundle_valid = 1'b0;
    slot_ready   = 1'b1;
    #1;
    vectors++;
    if ({slot_valid, word_addr, bundle_out, stall_cnt} !== {1'b0, 28'h0000600, b5, 16'd3}) begin
      miscompares++;
      $display("FAIL flush_after got v=%b a=%h cnt=%0d exp 0/0000600/3", slot_valid, word_addr, stall_cnt);
    end
    offer(b6, 28'h0000601);
    step();
    bundle_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, word_addr} !== {1'b1, 3'(k), 1'b0, 28'h0000601}) begin
        miscompares++;
        $display("FAIL flush_next k=%0d got v=%b i=%0d a=%h", k, slot_valid, slot_idx, word_addr);
      end
      step();
    end
  endtask

  task automatic test_nop();
    logic [127:0] b;
    // Nop in the first half of S4: a hidden cycle at (4,0) when skipping is built.
    b = {5'b00001, 3'b000, 24'h000abc, 24'ha5a5a5, 24'ha5a5a5, 24'ha5a5a5, 24'h000123};
    offer(b, 28'h0000700);
    slot_ready = 1'b1;
    step();
    bundle_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, last, bundle_ready} !==
          {!(SKIP_EN && k == 4), 3'((k < 5) ? k : 4), k == 5, k == 5, k == 5}) begin
        miscompares++;
        $display("FAIL nop_first k=%0d got %b exp %b", k, {slot_valid, slot_idx, sub12, last, bundle_ready},
                 {!(SKIP_EN && k == 4), 3'((k < 5) ? k : 4), k == 5, k == 5, k == 5});
      end
      step();
    end
    // Nop as the final item: the skip itself completes the bundle.
    b = {5'b00001, 3'b000, 24'ha5a5a5, 24'ha5a5a5, 24'ha5a5a5, 24'ha5a5a5, 24'h123000};
    offer(b, 28'h0000701);
    step();
    bundle_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if ({slot_valid, slot_idx, sub12, last, bundle_ready} !==
          {!(SKIP_EN && k == 5), 3'((k < 5) ? k : 4), k == 5, k == 5, k == 5}) begin
        miscompares++;
        $display("FAIL nop_last k=%0d got %b exp %b", k, {slot_valid, slot_idx, sub12, last, bundle_ready},
                 {!(SKIP_EN && k == 5), 3'((k < 5) ? k : 4), k == 5, k == 5, k == 5});
      end
      step();
    end
    #1;
    vectors++;
    if ({slot_valid, dbg_state} !== 2'b00) begin
      miscompares++;
      $display("FAIL nop_idle got %b exp 00", {slot_valid, dbg_state});
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_two12();
    test_all_two12();
    test_back_to_back();
    test_stall();
    test_flush();
    test_nop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
